decoder_2_to_4: RTL and testbench
=================================

Name: decoder_2_to_4

Overview:
- Gate-level 2-to-4 binary decoder with active-high enable and a registered one-hot output.
- Converts a 2-bit binary code into a 4-bit one-hot select word, for address/select generation in the textbook gate-level datapath.
- The decode network is built structurally from two enabled 1-to-2 decoder cells plus the enable logic. A single output register stage follows it.

Parameters:
- NUM_OF_BITS, 2, width of the binary input `a`. Fixed at 2 for this block; any other value is rejected at elaboration by an assertion.
- NUM_OF_OUTS, 2**NUM_OF_BITS (4), width of the one-hot output. Derived; not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ena  input  1  decode enable. 1 = decode `a`; 0 = force all outputs low.
- a  input  NUM_OF_BITS (2)  binary code to decode.
- out  output  NUM_OF_OUTS (4)  registered one-hot decode; bit i is high when `a == i` and `ena == 1`.

Behaviour:
- Combinational decode, gate-level only (AND/OR/NOT primitives or continuous assigns of those; no case statement, no shift operator):
  - dec_next[0] = ena & ~a[1] & ~a[0]
  - dec_next[1] = ena & ~a[1] &  a[0]
  - dec_next[2] = ena &  a[1] & ~a[0]
  - dec_next[3] = ena &  a[1] &  a[0]
- Structure: a[1] together with ena drives an enabled 1-to-2 decoder that produces two group enables. Each group enable drives its own 1-to-2 decoder on a[0].
- Register stage:
  - On each rising clk edge, `out <= dec_next`.
  - If rst = 1 at that edge, `out <= 4'b0000` instead.
  - Latency: exactly one clock from a change on a/ena to the corresponding change on out.
- Reset:
  - Synchronous; has no effect until the next clk edge.
  - Reset value of `out` is 4'b0000.
  - rst takes priority over ena/a.
  - Asserting rst mid-stream clears out on the next edge. The first edge after deassertion loads the decode of the current inputs.
- Output invariants:
  - When ena was 1 at the last edge (and rst 0), `out` has exactly one bit set (popcount = 1).
  - When ena was 0, `out == 0`.
  - `out` is never multi-hot.
- Input changes between edges are not visible on out; only the values sampled at the rising edge matter.
- No X propagation on out after reset, regardless of the input values.

Decomposition:
- Shared package decoder_pkg:
  - localparam DEC_IN_W = 2
  - localparam DEC_OUT_W = 4
  - typedef logic [DEC_IN_W-1:0] dec_code_t
  - typedef logic [DEC_OUT_W-1:0] dec_onehot_t
- One natural sub-module: decoder_1_to_2.
  - Ports: input en, input a, output [1:0] y.
  - Logic: y[0] = en & ~a; y[1] = en & a.
  - Instantiated three times: one stage on a[1], two stages on a[0].
- Output register lives in decoder_2_to_4.

Test Plan:
- Reset: hold rst=1, ena=1, a=2'b11 for 2 edges -> out==4'b0000. Release rst -> after the next edge out==4'b1000.
- Exhaustive enabled sweep: rst=0, ena=1, a=0,1,2,3 applied one per clock -> one edge later out==4'b0001, 4'b0010, 4'b0100, 4'b1000 respectively.
- Disable: ena=0 with a swept 0..3 -> out==4'b0000 after each edge. Re-enable with a=2'b01 -> next edge out==4'b0010.
- Latency/sampling:
  - Change a from 0 to 3 between edges -> out holds 4'b0001 until the next rising edge, then becomes 4'b1000.
  - A glitch on a that reverts before the edge is not reflected.
- Reset mid-operation: out==4'b0100 (a=2), assert rst for one edge -> out==4'b0000. Deassert rst -> next edge out==4'b0100.
- Randomized invariant check (≥1000 cycles, random rst/ena/a):
  - Compare out against a reference `ena ? (1<<a) : 0` delayed one cycle, and 0 after any reset edge.
  - Check popcount(out) ≤ 1 on every cycle.

Source files
------------

// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decoder_pkg
// Description : Shared widths and types for the gate-level 2-to-4 decoder.
//               DEC_IN_W  - width of the binary code
//               DEC_OUT_W - width of the one-hot select word
// Revision    : 1.0 - initial release
// ============================================================================
package decoder_pkg;

  localparam int DEC_IN_W  = 2;
  localparam int DEC_OUT_W = 4;

  typedef logic [DEC_IN_W-1:0]  dec_code_t;
  typedef logic [DEC_OUT_W-1:0] dec_onehot_t;

endpackage : decoder_pkg
`default_nettype wire

// File: rtl/decoder_1_to_2.sv
`default_nettype none
// ============================================================================
// Module      : decoder_1_to_2
// Description : Enabled 1-to-2 decoder cell, gate level.
//   en  in  1  cell enable; 0 forces both outputs low
//   a   in  1  select bit
//   y   out 2  y[0] = en & ~a, y[1] = en & a
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_1_to_2
  import decoder_pkg::*;
(
  input  logic       en,
  input  logic       a,
  output logic [1:0] y
);

  assign y[0] = en & ~a;
  assign y[1] = en &  a;

endmodule : decoder_1_to_2
`default_nettype wire

// File: rtl/decoder_2_to_4.sv
`default_nettype none
// ============================================================================
// Module      : decoder_2_to_4
// Description : 2-to-4 binary decoder with active-high enable and a
//               registered one-hot output. The decode tree is three
//               decoder_1_to_2 cells: one on a[1] gated by ena produces two
//               group enables, each of which enables a cell on a[0].
//   clk  in  1            rising-edge clock
//   rst  in  1            synchronous active-high reset (out -> 0)
//   ena  in  1            decode enable; 0 forces out to 0
//   a    in  NUM_OF_BITS  binary code
//   out  out NUM_OF_OUTS  registered one-hot decode, one clock latency
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_2_to_4
  import decoder_pkg::*;
#(
  parameter  int NUM_OF_BITS = 2,
  localparam int NUM_OF_OUTS = 2 ** NUM_OF_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [NUM_OF_BITS-1:0] a,
  output logic [NUM_OF_OUTS-1:0] out
);

  // The decode tree below is hand-built for exactly two code bits.
  if (NUM_OF_BITS != DEC_IN_W) begin : g_bad_width
    $error("decoder_2_to_4: NUM_OF_BITS must be 2");
  end

  logic [1:0]  grp_en;    // grp_en[1] selects codes 2/3, grp_en[0] codes 0/1
  dec_onehot_t dec_next;

  decoder_1_to_2 u_dec_hi (
    .en (ena),
    .a  (a[1]),
    .y  (grp_en)
  );

  decoder_1_to_2 u_dec_lo0 (
    .en (grp_en[0]),
    .a  (a[0]),
    .y  (dec_next[1:0])
  );

  decoder_1_to_2 u_dec_lo1 (
    .en (grp_en[1]),
    .a  (a[0]),
    .y  (dec_next[3:2])
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
    end else begin
      out <= dec_next;
    end
  end

endmodule : decoder_2_to_4
`default_nettype wire

// File: tb/tb_decoder_2_to_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_2_to_4
// Description : Directed and random self-checking bench for decoder_2_to_4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_2_to_4;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [1:0] a;
  logic [3:0] out;

  int n_checks;
  int n_fail;

  decoder_2_to_4 #(.NUM_OF_BITS(2)) dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .a   (a),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_tbl [4];
    logic [3:0] exp_q;
    logic       r_rst, r_ena;
    logic [1:0] r_a;

    n_checks = 0;
    n_fail   = 0;
    exp_tbl[0] = 4'b0001;
    exp_tbl[1] = 4'b0010;
    exp_tbl[2] = 4'b0100;
    exp_tbl[3] = 4'b1000;

    // Reset priority over an enabled decode.
    rst = 1'b1; ena = 1'b1; a = 2'b11;
    step();
    step();
    check("reset_hold", out, 4'b0000);
    rst = 1'b0;
    step();
    check("reset_release", out, 4'b1000);

    // Enabled sweep.
    for (int i = 0; i < 4; i++) begin
      a = 2'(i);
      step();
      check($sformatf("sweep_a%0d", i), out, exp_tbl[i]);
    end

    // Disabled sweep.
    ena = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 2'(i);
      step();
      check($sformatf("disabled_a%0d", i), out, 4'b0000);
    end
    ena = 1'b1; a = 2'b01;
    step();
    check("reenable", out, 4'b0010);

    // Input change between edges is invisible until the next edge.
    a = 2'b00;
    step();
    check("lat_base", out, 4'b0001);
    #2 a = 2'b11;
    #1 check("lat_hold", out, 4'b0001);
    step();
    check("lat_update", out, 4'b1000);

    // Glitch that reverts before the edge.
    a = 2'b00;
    step();
    #1 a = 2'b10;
    #1 a = 2'b00;
    step();
    check("glitch", out, 4'b0001);

    // Mid-stream reset.
    a = 2'b10;
    step();
    check("mid_pre", out, 4'b0100);
    rst = 1'b1;
    step();
    check("mid_reset", out, 4'b0000);
    rst = 1'b0;
    step();
    check("mid_release", out, 4'b0100);

    // Random stimulus against a one-cycle-delayed reference.
    for (int i = 0; i < 1200; i++) begin
      r_rst = ($urandom_range(0, 9) == 0);
      r_ena = ($urandom_range(0, 3) != 0);
      r_a   = 2'($urandom_range(0, 3));
      rst = r_rst; ena = r_ena; a = r_a;
      if (r_rst)      exp_q = 4'b0000;
      else if (r_ena) exp_q = 4'b0001 << r_a;
      else            exp_q = 4'b0000;
      step();
      check("rand_out", out, exp_q);
      check("rand_onehot", {3'b000, ($countones(out) <= 1)}, 4'b0001);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

endmodule : tb_decoder_2_to_4
`default_nettype wire
